risc_sequencer: RTL and testbench

RISC_SEQUENCER -- requirements
Module: risc_sequencer

---
 rtl/risc_sequencer_pkg.sv | 40 ++++
 rtl/risc_sequencer_phase_counter.sv | 26 ++
 rtl/risc_sequencer.sv | 141 ++++++++++++++
 tb/tb_risc_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/risc_sequencer_pkg.sv
// Shared CPU package: phase and opcode encodings, sequencer state type and the ALU-op decode.
package risc_sequencer_pkg;

    localparam int PH_W = 3;
    localparam int OP_W = 3;

    typedef enum logic [PH_W-1:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    typedef enum logic [OP_W-1:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_WAIT   = 2'd2
    } seq_state_e;

    // Opcodes whose operand is read from memory into the accumulator path.
    function automatic logic is_aluop(input opcode_e op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/risc_sequencer_phase_counter.sv
// 3-bit instruction phase counter with asynchronous active-low clear and count enable.
module phase_counter
    import risc_sequencer_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    output logic [PH_W-1:0] phase_o
);

    logic [PH_W-1:0] phase_q;
    logic [PH_W-1:0] phase_d;

    assign phase_d = en_i ? (phase_q + 1'b1) : phase_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/risc_sequencer.sv
// Eight-phase RISC control sequencer: phase counter plus run/halt/wait FSM and output decode.
// Optional single-step WAIT state is built when RISC_SEQ_STEP_EN is defined.
//
//   state     | meaning
//   ST_RUN    | phase counter advances, outputs decoded from phase and opcode
//   ST_HALTED | HLT seen at OP_ADDR; halt=1, counter frozen until reset
//   ST_WAIT   | instruction finished, waiting for step (RISC_SEQ_STEP_EN only)
module risc_sequencer
    import risc_sequencer_pkg::*;
#(
    parameter int OP_W = risc_sequencer_pkg::OP_W
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
`ifdef RISC_SEQ_STEP_EN
    input  logic            step,
`endif
    output logic            sel,
    output logic            rd,
    output logic            ld_ir,
    output logic            inc_pc,
    output logic            halt,
    output logic            ld_pc,
    output logic            data_e,
    output logic            ld_ac,
    output logic            wr
);

    seq_state_e      state_q;
    seq_state_e      state_d;
    logic [PH_W-1:0] phase_cnt;
    phase_e          phase;
    opcode_e         op;
    logic            hlt_hit;
    logic            cnt_en;
    logic            aluop;

    assign op      = opcode_e'(opcode[2:0]);
    assign phase   = phase_e'(phase_cnt);
    assign aluop   = is_aluop(op);
    assign hlt_hit = (phase == PH_OP_ADDR) && (op == OP_HLT);
    // Hold the counter on the halting edge so the frozen phase stays at OP_ADDR.
    assign cnt_en  = (state_q == ST_RUN) && !hlt_hit;

    phase_counter u_phase_counter (
        .clk_i   (clk),
        .rst_ni  (rst),
        .en_i    (cnt_en),
        .phase_o (phase_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (hlt_hit) begin
                    state_d = ST_HALTED;
                end else if (phase == PH_STORE) begin
`ifdef RISC_SEQ_STEP_EN
                    state_d = ST_WAIT;
`else
                    state_d = ST_RUN;
`endif
                end
            end
            ST_WAIT: begin
`ifdef RISC_SEQ_STEP_EN
                if (step) begin
                    state_d = ST_RUN;
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        halt   = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        if (state_q == ST_HALTED) begin
            halt = 1'b1;
        end else if (state_q == ST_RUN) begin
            unique case (phase)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (op == OP_HLT);
                end
                PH_OP_FETCH: begin
                    rd = aluop;
                end
                PH_ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (op == OP_SKZ) && zero;
                    ld_pc  = (op == OP_JMP);
                    data_e = (op == OP_STO);
                end
                PH_STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (op == OP_JMP);
                    wr     = (op == OP_STO);
                    data_e = (op == OP_STO);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_sequencer.sv
// Directed bench for risc_sequencer; output vectors are {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr}.
`timescale 1ns/1ps
module tb_risc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
`ifdef RISC_SEQ_STEP_EN
    logic       step = 1'b1;
`endif
    logic sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
    logic [8:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign outs = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

    risc_sequencer #(.OP_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
`ifdef RISC_SEQ_STEP_EN
        .step   (step),
`endif
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .halt   (halt),
        .ld_pc  (ld_pc),
        .data_e (data_e),
        .ld_ac  (ld_ac),
        .wr     (wr)
    );

    localparam logic [8:0] O_SEL  = 9'b100000000;
    localparam logic [8:0] O_HALT = 9'b000010000;

    typedef logic [8:0] vec8_t [8];

    localparam vec8_t T_ADD    = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                                   9'b000100000, 9'b010000000, 9'b010000000, 9'b010000010};
    localparam vec8_t T_SKZ_Z1 = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                                   9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000};
    localparam vec8_t T_SKZ_Z0 = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                                   9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000};
    localparam vec8_t T_JMP    = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                                   9'b000100000, 9'b000000000, 9'b000001000, 9'b000001000};
    localparam vec8_t T_STO    = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                                   9'b000100000, 9'b000000000, 9'b000000100, 9'b000000101};

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Entered and left at a falling edge; leaves the block in phase 0.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1 check("reset_outs", outs, O_SEL);
        @(negedge clk);
        check("reset_held", outs, O_SEL);
        rst = 1'b1;
    endtask

    task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                             input vec8_t tbl);
        opcode = op;
        zero   = z;
        for (int p = 0; p < 8; p++) begin
            #1 check($sformatf("%s_ph%0d", tag, p), outs, tbl[p]);
            @(negedge clk);
        end
`ifdef RISC_SEQ_STEP_EN
        #1 check({tag, "_wait"}, outs, 9'b000000000);
        @(negedge clk);
`endif
    endtask

    initial begin
        do_reset();

        run_instr("add", 3'd2, 1'b0, T_ADD);
        #1 check("add_wrap_ph0", outs, O_SEL);

        run_instr("skz_z1", 3'd1, 1'b1, T_SKZ_Z1);
        run_instr("skz_z0", 3'd1, 1'b0, T_SKZ_Z0);
        run_instr("jmp", 3'd7, 1'b0, T_JMP);
        run_instr("sto", 3'd6, 1'b1, T_STO);

        // HLT: normal fetch, halt at OP_ADDR, then sticky HALTED.
        opcode = 3'd0;
        zero   = 1'b0;
        for (int p = 0; p < 4; p++) begin
            #1 check($sformatf("hlt_ph%0d", p), outs, T_ADD[p]);
            @(negedge clk);
        end
        #1 check("hlt_ph4", outs, 9'b000110000);
        @(negedge clk);
        opcode = 3'd2;
        for (int c = 0; c < 20; c++) begin
            #1 check($sformatf("halted_%0d", c), outs, O_HALT);
            @(negedge clk);
        end
        #3 rst = 1'b0;
        #1 check("hlt_rst_async", outs, O_SEL);
        @(negedge clk);
        rst = 1'b1;
        #1 check("hlt_rst_ph0", outs, O_SEL);
        @(negedge clk);
        #1 check("hlt_rst_ph1", outs, 9'b110000000);
        @(negedge clk);

        // Realign to phase 0, then assert reset asynchronously in the middle of phase 5.
        do_reset();
        opcode = 3'd2;
        for (int p = 0; p < 5; p++) @(negedge clk);
        #1 check("mid5_before", outs, 9'b010000000);
        #1 rst = 1'b0;
        #1 check("mid5_async", outs, O_SEL);
        @(negedge clk);
        check("mid5_held", outs, O_SEL);
        rst = 1'b1;
        #1 check("mid5_rel_ph0", outs, O_SEL);
        @(negedge clk);
        #1 check("mid5_rel_ph1", outs, 9'b110000000);
        @(negedge clk);

`ifdef RISC_SEQ_STEP_EN
        do_reset();
        step   = 1'b0;
        opcode = 3'd4;
        for (int p = 0; p < 8; p++) begin
            #1 check($sformatf("xor_ph%0d", p), outs, T_ADD[p]);
            @(negedge clk);
        end
        for (int c = 0; c < 5; c++) begin
            #1 check($sformatf("xor_wait_%0d", c), outs, 9'b000000000);
            @(negedge clk);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        #1 check("xor_step_ph0", outs, O_SEL);
        @(negedge clk);
        #1 check("xor_step_ph1", outs, 9'b110000000);
        step = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
